// File: rtl/lab_2_sweep_driver_if.sv
// Bundle between the sweep driver and the world around it: the lab_2 operand
// lines (a, b, c), lab_2's answers (y_in, x_in), the sweep request and the
// captured truth table.
//
// Modports:
//   master - the sweep driver: consumes start/y_in/x_in, drives everything else.
//   slave  - whoever requests sweeps and models/hosts lab_2.
interface lab_2_sweep_driver_if;
  logic        start;
  logic        a;
  logic        b;
  logic        c;
  logic        y_in;
  logic        x_in;
  logic        busy;
  logic        done;
  logic [2:0]  vec_idx;
  logic [15:0] result;

  modport master (
    input  start,
    input  y_in,
    input  x_in,
    output a,
    output b,
    output c,
    output busy,
    output done,
    output vec_idx,
    output result
  );

  modport slave (
    output start,
    output y_in,
    output x_in,
    input  a,
    input  b,
    input  c,
    input  busy,
    input  done,
    input  vec_idx,
    input  result
  );
endinterface

// File: rtl/lab_2_sweep_driver.sv
// Exhaustive stimulus driver for the lab_2 combinational block.
//
// On an accepted start it walks {a,b,c} through 0..7, holding each vector for
// DWELL cycles. On the last dwell cycle of each vector it captures lab_2's
// y/x into result[2i+1]/result[2i], then pulses done once after vector 7.
//
// Ports:
//   clk  - system clock, rising edge.
//   rst  - asynchronous, active-high reset.
//   bus  - lab_2_sweep_driver_if.master:
//            start   in   sweep request, only honoured while idle
//            y_in    in   lab_2.y
//            x_in    in   lab_2.x
//            a,b,c   out  lab_2 operands, {a,b,c} == vec_idx
//            busy    out  sweep in progress
//            done    out  one-cycle completion pulse
//            vec_idx out  current vector index
//            result  out  captured truth table, held until the next start
//
// Every output is taken straight from a flop.
module lab_2_sweep_driver #(
  parameter int unsigned DWELL = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  lab_2_sweep_driver_if.master bus
);

  localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StFinish
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       result_q, result_d;

  logic dwell_last;
  logic vec_last;

  assign dwell_last = (cnt_q == CntLast);
  assign vec_last   = (vec_q == 3'd7);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      vec_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vec_q    <= vec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (dwell_last && vec_last) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (bus.start) begin
          // A new sweep wipes the previous table so unsampled slots read 0.
          vec_d    = 3'd0;
          cnt_d    = '0;
          result_d = 16'h0000;
          busy_d   = 1'b1;
        end
      end
      StDrive: begin
        busy_d = 1'b1;
        if (dwell_last) begin
          // lab_2 has had the whole dwell to settle on the current vector.
          result_d[{vec_q, 1'b1}] = bus.y_in;
          result_d[{vec_q, 1'b0}] = bus.x_in;
          cnt_d = '0;
          if (vec_last) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            vec_d = vec_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFinish: begin
        // Operands stay on vector 7 through this cycle and return to 0 on exit.
        vec_d  = 3'd0;
        cnt_d  = '0;
        busy_d = 1'b0;
      end
      default: begin
        vec_d  = 3'd0;
        cnt_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.a       = vec_q[2];
  assign bus.b       = vec_q[1];
  assign bus.c       = vec_q[0];
  assign bus.vec_idx = vec_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;

endmodule

// File: tb/tb_lab_2_sweep_driver.sv
`timescale 1ns/1ps
module tb_lab_2_sweep_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  lab_2_sweep_driver_if bus0 ();
  lab_2_sweep_driver_if bus1 ();

  lab_2_sweep_driver #(.DWELL(10)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  lab_2_sweep_driver #(.DWELL(2))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // ---------------------------------------------------------------------------
  // Reference model: the response source behind y_in/x_in.
  //   mode 0: lab_2 (y = a & b, x = c)   mode 1: y=1,x=0
  //   mode 2: y=0,x=1                     mode 3: arbitrary table tt
  // ---------------------------------------------------------------------------
  int          mode0 = 0, mode1 = 0;
  logic [15:0] tt0 = 16'h0, tt1 = 16'h0;

  function automatic logic [1:0] ref_pair(input int m, input logic [15:0] t, input int i);
    logic av, bv, cv;
    av = i[2];
    bv = i[1];
    cv = i[0];
    case (m)
      0:       return {av & bv, cv};
      1:       return 2'b10;
      2:       return 2'b01;
      default: return {t[2*i+1], t[2*i]};
    endcase
  endfunction

  function automatic logic [15:0] exp_table(input int m, input logic [15:0] t);
    logic [15:0] r;
    r = 16'h0;
    for (int i = 0; i < 8; i++) begin
      r[2*i+:2] = ref_pair(m, t, i);
    end
    return r;
  endfunction

  logic [1:0] pair0, pair1;
  always_comb begin
    pair0 = ref_pair(mode0, tt0, int'({bus0.a, bus0.b, bus0.c}));
    bus0.y_in = pair0[1];
    bus0.x_in = pair0[0];
  end
  always_comb begin
    pair1 = ref_pair(mode1, tt1, int'({bus1.a, bus1.b, bus1.c}));
    bus1.y_in = pair1[1];
    bus1.x_in = pair1[0];
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int          e0;
    logic [15:0] res;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] lr0 = 16'h0;
  logic [15:0] lr1 = 16'h0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, got, want);
    end
  endtask

  // got = {busy, done, vec_idx, a, b, c, result}
  task automatic mon(input int which, input int dw, input logic [31:0] got);
    exp_t        f;
    bit          have;
    int          t;
    int          k;
    logic [15:0] last;
    logic [15:0] part;
    logic [31:0] want;
    have = 1'b0;
    if (which == 0) begin
      last = lr0;
      if (q0.size() > 0) begin have = 1'b1; f = q0[0]; end
    end else begin
      last = lr1;
      if (q1.size() > 0) begin have = 1'b1; f = q1[0]; end
    end
    if (!have || cyc < f.e0) begin
      want = {8'h0, 1'b0, 1'b0, 3'd0, 3'd0, last};
      check(which == 0 ? "idle0" : "idle1", got, want);
    end else begin
      t = cyc - f.e0;
      k = t / dw;
      if (t < 8 * dw) begin
        part = f.res & ((16'h1 << (2 * k)) - 16'h1);
        want = {8'h0, 1'b1, 1'b0, k[2:0], k[2:0], part};
        check(which == 0 ? "drive0" : "drive1", got, want);
      end else begin
        want = {8'h0, 1'b0, 1'b1, 3'd7, 3'd7, f.res};
        check(which == 0 ? "done0" : "done1", got, want);
        if (which == 0) begin void'(q0.pop_front()); lr0 = f.res; end
        else            begin void'(q1.pop_front()); lr1 = f.res; end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, 10, {8'h0, bus0.busy, bus0.done, bus0.vec_idx, bus0.a, bus0.b, bus0.c, bus0.result});
      mon(1, 2,  {8'h0, bus1.busy, bus1.done, bus1.vec_idx, bus1.a, bus1.b, bus1.c, bus1.result});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic start_sweep(input int which, input int m, input logic [15:0] t,
                             input bit hold, output int e0);
    exp_t e;
    @(negedge clk);
    if (which == 0) begin mode0 = m; tt0 = t; bus0.start = 1'b1; end
    else            begin mode1 = m; tt1 = t; bus1.start = 1'b1; end
    @(posedge clk);
    #1;
    e0    = cyc;
    e.e0  = e0;
    e.res = exp_table(m, t);
    if (which == 0) q0.push_back(e);
    else            q1.push_back(e);
    if (!hold) begin
      @(negedge clk);
      if (which == 0) bus0.start = 1'b0;
      else            bus1.start = 1'b0;
    end
  endtask

  task automatic drain(input int which, input int limit);
    int n;
    int left;
    n = 0;
    left = (which == 0) ? q0.size() : q1.size();
    while (left != 0 && n < limit) begin
      @(negedge clk);
      n++;
      left = (which == 0) ? q0.size() : q1.size();
    end
    check("drain_timeout", left, 0);
    if (which == 0) q0.delete();
    else            q1.delete();
  endtask

  initial begin
    int          e0;
    int          m;
    logic [15:0] t;
    exp_t        e;
    logic [31:0] got;

    bus0.start = 1'b0;
    bus1.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // lab_2 model sweep
    start_sweep(0, 0, 16'h0, 1'b0, e0);
    drain(0, 120);
    check("lab2_table", bus0.result, 16'hE444);

    // constant responses, result cleared by each new start
    start_sweep(0, 1, 16'h0, 1'b0, e0);
    drain(0, 120);
    check("const_y1", bus0.result, 16'hAAAA);
    start_sweep(0, 2, 16'h0, 1'b0, e0);
    drain(0, 120);
    check("const_x1", bus0.result, 16'h5555);

    // start during a sweep is ignored
    start_sweep(0, 0, 16'h0, 1'b0, e0);
    while (cyc < e0 + 32) @(negedge clk);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    drain(0, 120);
    repeat (10) @(negedge clk);

    // randomized tables and idle gaps
    for (int r = 0; r < 6; r++) begin
      m = $urandom_range(0, 3);
      t = 16'($urandom);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      start_sweep(0, m, t, 1'b0, e0);
      drain(0, 120);
    end

    // async reset mid-sweep at vector 5
    start_sweep(0, 3, 16'($urandom), 1'b0, e0);
    while (cyc < e0 + 52) @(negedge clk);
    #2;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    lr0 = 16'h0;
    lr1 = 16'h0;
    #1;
    got = {8'h0, bus0.busy, bus0.done, bus0.vec_idx, bus0.a, bus0.b, bus0.c, bus0.result};
    check("async_reset", got, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // DWELL=2, start held: two sweeps 18 cycles apart
    start_sweep(1, 0, 16'h0, 1'b1, e0);
    e.e0  = e0 + 18;
    e.res = exp_table(0, 16'h0);
    q1.push_back(e);
    drain(1, 100);
    bus1.start = 1'b0;
    check("dwell2_table", bus1.result, 16'hE444);
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
